// File: rtl/count_scheduler_pkg.sv
// Shared definitions for the round-robin counter scheduler: FSM state
// encoding and default counter width / requester count.
package count_scheduler_pkg;

    localparam int DEF_SIZE = 4;
    localparam int DEF_N    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/count_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting
// one past the last served requester and reports the first active one.
module count_scheduler_rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_id,
    output logic           valid,
    output logic [IDW-1:0] winner
);

    int idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        // k = N wraps back to last_id itself, so it is considered last
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_id) + k) % N;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// Shares one up-counter between N requesters: grants one job at a time in
// round-robin order, counts from its start to its terminal value, pulses done.
module count_scheduler
    import count_scheduler_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int N    = DEF_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*SIZE-1:0]     init_val,
    input  logic [N*SIZE-1:0]     term_val,
    output logic [N-1:0]          grant,
    output logic                  busy,
    output logic                  done,
    output logic [$clog2(N)-1:0]  done_id,
    output logic [SIZE-1:0]       count,
    output logic                  co
);

    localparam int IDW = $clog2(N);

    state_t          state, state_nx;
    logic [N-1:0]    grant_nx;
    logic [SIZE-1:0] count_nx;
    logic [SIZE-1:0] term_q;
    logic [IDW-1:0]  id_q, id_nx;
    logic [IDW-1:0]  last_id, last_id_nx;
    logic            load;
    logic            arb_valid;
    logic [IDW-1:0]  winner;
    logic            at_term;

    count_scheduler_rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_arbiter (
        .req     (req),
        .last_id (last_id),
        .valid   (arb_valid),
        .winner  (winner)
    );

    assign at_term = (count == term_q);

    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        count_nx   = count;
        id_nx      = id_q;
        last_id_nx = last_id;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nx         = ST_RUN;
                    grant_nx         = '0;
                    grant_nx[winner] = 1'b1;
                    count_nx         = init_val[winner*SIZE +: SIZE];
                    id_nx            = winner;
                    load             = 1'b1;
                end
            end
            ST_RUN: begin
                // a dropped request wins over reaching the terminal value
                if (!req[id_q]) begin
                    state_nx   = ST_IDLE;
                    grant_nx   = '0;
                    last_id_nx = id_q;
                end else if (at_term) begin
                    state_nx = ST_DONE;
                end else begin
                    count_nx = count + 1'b1;
                end
            end
            ST_DONE: begin
                state_nx   = ST_IDLE;
                grant_nx   = '0;
                last_id_nx = id_q;
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            count   <= '0;
            id_q    <= '0;
            last_id <= IDW'(N - 1);
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            count   <= count_nx;
            id_q    <= id_nx;
            last_id <= last_id_nx;
        end
    end

    // terminal value is pure data: only meaningful once a job has been loaded
    always_ff @(posedge clk) begin
        if (load) begin
            term_q <= term_val[winner*SIZE +: SIZE];
        end
    end

    assign busy    = (state == ST_RUN) || (state == ST_DONE);
    assign done    = (state == ST_DONE);
    assign done_id = done ? id_q : '0;
    assign co      = (state == ST_RUN) && at_term;

endmodule

// File: tb/tb_count_scheduler.sv
// Self-checking bench for count_scheduler: directed vector table, corner-case
// sequences and randomized traffic against a job-level reference model.
module tb_count_scheduler;

    localparam int SIZE = 4;
    localparam int N    = 4;
    localparam int MODV = 1 << SIZE;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N*SIZE-1:0]    init_val;
    logic [N*SIZE-1:0]    term_val;
    logic [N-1:0]         grant;
    logic                 busy;
    logic                 done;
    logic [$clog2(N)-1:0] done_id;
    logic [SIZE-1:0]      count;
    logic                 co;

    count_scheduler #(.SIZE(SIZE), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .init_val (init_val),
        .term_val (term_val),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .count    (count),
        .co       (co)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] i0;
        logic [3:0] t0;
        logic [3:0] g;
        logic       b;
        logic       d;
        logic [1:0] di;
        logic [3:0] c;
        logic       co;
    } vec_t;

    vec_t tbl[7];

    // job-level reference model state
    bit m_active;
    bit m_finished;
    int m_id;
    int m_init;
    int m_len;
    int m_elapsed;
    int m_count;
    int m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int g, input int b, input int d,
                             input int di, input int c, input int co_e);
        check({name, "_grant"},   32'(grant),   g);
        check({name, "_busy"},    32'(busy),    b);
        check({name, "_done"},    32'(done),    d);
        check({name, "_done_id"}, 32'(done_id), di);
        check({name, "_count"},   32'(count),   c);
        check({name, "_co"},      32'(co),      co_e);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // asynchronous reset pulse that never spans a clock edge
    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check_out(name, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_reset;
        m_active   = 0;
        m_finished = 0;
        m_id       = 0;
        m_init     = 0;
        m_len      = 0;
        m_elapsed  = 0;
        m_count    = 0;
        m_last     = N - 1;
    endtask

    // advance the model by one clock using the inputs present before the edge
    task automatic model_step;
        int cur;
        int i;
        if (m_active && m_finished) begin
            m_active   = 0;
            m_finished = 0;
            m_last     = m_id;
        end else if (m_active) begin
            cur = (m_init + m_elapsed) % MODV;
            if (!req[m_id]) begin
                m_active = 0;
                m_last   = m_id;
                m_count  = cur;
            end else if (m_elapsed == m_len) begin
                m_finished = 1;
                m_count    = cur;
            end else begin
                m_elapsed++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (!m_active && req[i]) begin
                    m_active  = 1;
                    m_id      = i;
                    m_init    = int'(init_val[i*SIZE +: SIZE]);
                    m_len     = (int'(term_val[i*SIZE +: SIZE]) - m_init + MODV) % MODV;
                    m_elapsed = 0;
                end
            end
        end
    endtask

    task automatic model_check;
        bit run;
        int c;
        run = m_active && !m_finished;
        c   = run ? (m_init + m_elapsed) % MODV : m_count;
        check_out("rand",
                  m_active ? (1 << m_id) : 0,
                  int'(m_active),
                  int'(m_finished),
                  m_finished ? m_id : 0,
                  c,
                  int'(run && (m_elapsed == m_len)));
    endtask

    initial begin
        tbl[0] = '{4'b0001, 4'd2, 4'd5, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd2, 1'b0};
        tbl[1] = '{4'b0001, 4'd9, 4'd3, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd3, 1'b0};
        tbl[2] = '{4'b0001, 4'd0, 4'd0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd4, 1'b0};
        tbl[3] = '{4'b0001, 4'd2, 4'd5, 4'b0001, 1'b1, 1'b0, 2'd0, 4'd5, 1'b1};
        tbl[4] = '{4'b0001, 4'd2, 4'd5, 4'b0001, 1'b1, 1'b1, 2'd0, 4'd5, 1'b0};
        tbl[5] = '{4'b0000, 4'd2, 4'd5, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd5, 1'b0};
        tbl[6] = '{4'b0000, 4'd2, 4'd5, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd5, 1'b0};

        rst      = 1'b1;
        req      = '0;
        init_val = '0;
        term_val = '0;
        #2;
        do_reset("reset");

        // basic job from the vector table
        for (int r = 0; r < 7; r++) begin
            req      = tbl[r].req;
            init_val = {12'h000, tbl[r].i0};
            term_val = {12'h000, tbl[r].t0};
            tick();
            check_out($sformatf("tbl%0d", r), int'(tbl[r].g), int'(tbl[r].b), int'(tbl[r].d),
                      int'(tbl[r].di), int'(tbl[r].c), int'(tbl[r].co));
        end

        // round robin with all requesters active, D=1 jobs, period 4
        do_reset("rr_rst");
        req      = 4'b1111;
        init_val = 16'h0000;
        term_val = 16'h1111;
        for (int j = 0; j < 5; j++) begin
            tick();
            check_out($sformatf("rr%0d_run0", j), 1 << (j % N), 1, 0, 0, 0, 0);
            tick();
            check_out($sformatf("rr%0d_run1", j), 1 << (j % N), 1, 0, 0, 1, 1);
            tick();
            check_out($sformatf("rr%0d_done", j), 1 << (j % N), 1, 1, j % N, 1, 0);
            tick();
            check_out($sformatf("rr%0d_idle", j), 0, 0, 0, 0, 1, 0);
        end

        // wrap-around 14 -> 15 -> 0 -> 1
        do_reset("wrap_rst");
        req      = 4'b0001;
        init_val = 16'h000E;
        term_val = 16'h0001;
        tick(); check_out("wrap_c14", 1, 1, 0, 0, 14, 0);
        tick(); check_out("wrap_c15", 1, 1, 0, 0, 15, 0);
        tick(); check_out("wrap_c0",  1, 1, 0, 0, 0, 0);
        tick(); check_out("wrap_c1",  1, 1, 0, 0, 1, 1);
        tick(); check_out("wrap_done", 1, 1, 1, 0, 1, 0);

        // zero-length job
        do_reset("eq_rst");
        init_val = 16'h0007;
        term_val = 16'h0007;
        tick(); check_out("eq_run",  1, 1, 0, 0, 7, 1);
        tick(); check_out("eq_done", 1, 1, 1, 0, 7, 0);

        // drop on the terminal cycle: abort wins, no done
        do_reset("prio_rst");
        init_val = 16'h0005;
        term_val = 16'h0005;
        tick(); check_out("prio_run", 1, 1, 0, 0, 5, 1);
        req = 4'b0000;
        tick(); check_out("prio_abort", 0, 0, 0, 0, 5, 0);

        // abort at count 3, then round robin moves on to requester 2
        do_reset("abort_rst");
        req      = 4'b0110;
        init_val = 16'h0900;
        term_val = 16'h0FA0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_out($sformatf("abort_c%0d", c), 2, 1, 0, 0, c, 0);
        end
        req = 4'b0100;
        tick(); check_out("abort_idle", 0, 0, 0, 0, 3, 0);
        tick(); check_out("abort_next", 4, 1, 0, 0, 9, 0);

        // asynchronous reset in the middle of a job
        do_reset("mid_rst0");
        req      = 4'b0001;
        init_val = 16'h0000;
        term_val = 16'h000F;
        for (int c = 0; c < 7; c++) tick();
        check_out("mid_c6", 1, 1, 0, 0, 6, 0);
        do_reset("mid_rst");
        req      = 4'b1111;
        init_val = 16'h3333;
        term_val = 16'h3333;
        tick(); check_out("mid_after", 1, 1, 0, 0, 3, 1);

        // randomized traffic against the reference model
        do_reset("rand_rst");
        model_reset();
        req = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            init_val = 16'($urandom);
            term_val = 16'($urandom);
            model_step();
            tick();
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
